// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the architectural PC, keeps one fetch outstanding to
// instruction memory, and hands {pc, pc+4, instr} to decode under a valid/stall handshake.
module pc_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc4_o,
    output logic [31:0]     if_instr_o,
    output logic            misalign_o,
    output logic [1:0]      dbg_state
);

    // Handshakes: memory accepts a request on a cycle with imem_req_o & imem_gnt_i and answers
    // with a single imem_rvalid_i pulse at least one cycle later; decode takes an instruction on
    // a cycle with if_valid_o & !stall_i.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;
    logic            drop_q, drop_d;
    logic            slot_free;
    logic            accept;
    logic            load;
    logic            redir_live;

    assign slot_free   = !if_valid_o || !stall_i;
    assign redir_live  = redirect_i && (state_q != IDLE);
    assign target      = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign imem_addr_o = pc_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        imem_req_o = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req_o = slot_free;
                accept     = slot_free && imem_gnt_i;
                if (accept) state_d = WAIT;
                // A fetch accepted alongside a redirect is already stale.
                if (redir_live) begin
                    pc_d   = target;
                    drop_d = accept;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                    if (redir_live) begin
                        pc_d = target;
                    end else if (!drop_q) begin
                        load = 1'b1;
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (redir_live) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Redirect flush outranks both a new load and a consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_pc4_o   <= '0;
            if_instr_o <= NOP_INSTR;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redir_live && (redirect_pc_i[1:0] != 2'b00);
            if (redir_live) begin
                if_valid_o <= 1'b0;
            end else if (load) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc_q;
                if_pc4_o   <= pc_q + PC_STEP;
                if_instr_o <= imem_rdata_i;
            end else if (if_valid_o && !stall_i) begin
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a memory/decode driver, a reference model of fetch order and
// redirects, and a scoreboard monitor that checks every instruction handed to decode.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic [31:0] if_instr_o;
    logic        misalign_o;
    logic [1:0]  dbg_state;

    pc_fetch_unit #(
        .XLEN(32),
        .RESET_VEC(RESET_VEC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o),
        .if_pc_o(if_pc_o),
        .if_pc4_o(if_pc4_o),
        .if_instr_o(if_instr_o),
        .misalign_o(misalign_o),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [95:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit          m_idle;
    bit          m_pend;
    bit          m_stale;
    bit          m_valid;
    bit          exp_mis;
    logic [31:0] m_pc;
    logic [31:0] m_pend_addr;
    logic [31:0] m_pend_data;
    logic [31:0] m_out_pc, m_out_pc4, m_out_instr;
    int          wait_cnt;

    int p_gnt, p_stall, p_redir, max_delay;
    bit fixed_data;

    // Evaluated on the falling edge: inputs and outputs are stable for the coming rising edge.
    task automatic model_eval();
        bit          exp_req, acc, redir, rsp, consume, deliver;
        logic [31:0] tgt;
        if (rst) begin
            m_idle = 1; m_pend = 0; m_stale = 0; m_valid = 0; exp_mis = 0;
            m_pc = RESET_VEC;
            m_out_pc = 32'h0; m_out_pc4 = 32'h0; m_out_instr = NOP_INSTR;
            exp_q.delete();
            return;
        end
        exp_req = !m_idle && !m_pend && (!m_valid || !stall_i);
        check("imem_req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr_o, m_pc);
        check("if_valid", 32'(if_valid_o), 32'(m_valid));
        check("if_pc", if_pc_o, m_out_pc);
        check("if_pc4", if_pc4_o, m_out_pc4);
        check("if_instr", if_instr_o, m_out_instr);
        check("misalign", 32'(misalign_o), 32'(exp_mis));

        if (m_idle) begin
            m_idle  = 0;
            exp_mis = 0;
            return;
        end
        acc     = exp_req && imem_gnt_i;
        redir   = redirect_i;
        tgt     = {redirect_pc_i[31:2], 2'b00};
        rsp     = imem_rvalid_i && m_pend;
        consume = m_valid && !stall_i;
        deliver = 0;
        exp_mis = redir && (redirect_pc_i[1:0] != 2'b00);

        if (acc) begin
            m_pend      = 1;
            m_pend_addr = m_pc;
            m_pend_data = fixed_data ? 32'h0050_0093 : $urandom;
            m_stale     = redir;
            wait_cnt    = $urandom_range(max_delay, 0);
        end else if (rsp) begin
            m_pend = 0;
            if (!m_stale && !redir) begin
                deliver = 1;
                exp_q.push_back({m_pend_addr, m_pend_addr + 32'd4, m_pend_data});
                m_out_pc    = m_pend_addr;
                m_out_pc4   = m_pend_addr + 32'd4;
                m_out_instr = m_pend_data;
                m_pc        = m_pend_addr + 32'd4;
            end
        end else if (m_pend && redir) begin
            m_stale = 1;
        end

        if (redir)        begin m_pc = tgt; m_valid = 0; end
        else if (deliver) m_valid = 1;
        else if (consume) m_valid = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_mem();
        if (m_pend && wait_cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = m_pend_data;
        end else begin
            if (m_pend) wait_cnt--;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    task automatic drive_random();
        logic [31:0] t;
        imem_gnt_i = ($urandom_range(99, 0) < p_gnt);
        stall_i    = ($urandom_range(99, 0) < p_stall);
        redirect_i = ($urandom_range(99, 0) < p_redir);
        t = $urandom;
        if ($urandom_range(9, 0) == 0) t = 32'hFFFF_FFFC | 32'($urandom_range(3, 0));
        redirect_pc_i = t;
        drive_mem();
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_random();
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    bit          prev_v = 0;
    logic [95:0] mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
        end else begin
            if (if_valid_o && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %08h, expected no instruction", if_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_pc", if_pc_o, mon_e[95:64]);
                    check("sb_pc4", if_pc4_o, mon_e[63:32]);
                    check("sb_instr", if_instr_o, mon_e[31:0]);
                end
            end
            prev_v = if_valid_o;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit fired;
        rst = 1'b1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        p_gnt = 100; p_stall = 0; p_redir = 0; max_delay = 0; fixed_data = 1;
        do_reset();

        // Back-to-back fetch from the reset vector, fixed instruction word.
        run(8);

        // Hold decode stalled for five cycles while an instruction is presented.
        for (int i = 0; i < 20 && !m_valid; i++) run(1);
        check("stall_setup", 32'(m_valid), 32'd1);
        repeat (5) begin
            drive_random();
            stall_i = 1'b1;
            tick();
        end
        run(6);

        // Redirect to 0x100 on the very cycle 0x8 is accepted.
        do_reset();
        fired = 0;
        for (int i = 0; i < 40 && !fired; i++) begin
            drive_random();
            if (!m_idle && !m_pend && m_pc == 32'h8 && (!m_valid || !stall_i)) begin
                redirect_i    = 1'b1;
                redirect_pc_i = 32'h100;
                imem_gnt_i    = 1'b1;
                fired = 1;
            end
            tick();
        end
        check("redir_accept_fired", 32'(fired), 32'd1);
        run(10);

        // Misaligned target, then the top-of-memory wrap.
        drive_random();
        redirect_i = 1'b1; redirect_pc_i = 32'h202;
        tick();
        run(8);
        drive_random();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        run(10);

        // Reset while a fetch is outstanding; a late response must be ignored.
        max_delay = 3;
        for (int i = 0; i < 20 && !m_pend; i++) run(1);
        check("rst_wait_setup", 32'(m_pend), 32'd1);
        rst = 1'b1; imem_gnt_i = 0; redirect_i = 0; stall_i = 0; imem_rvalid_i = 0;
        tick();
        rst = 1'b0;
        repeat (2) begin
            drive_random();
            imem_gnt_i = 1'b0; redirect_i = 1'b0;
            imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
            tick();
        end
        run(10);

        // Randomized traffic.
        p_gnt = 70; p_stall = 30; p_redir = 6; max_delay = 3; fixed_data = 0;
        run(4000);

        // Drain: stop issuing and let any response return.
        p_redir = 0; p_stall = 0; p_gnt = 0;
        run(12);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
